// File: rtl/reg_file_sb.sv
// reg_file_sb: scoreboarded register file.
// Two combinational read ports, one write port, and a per-register busy bit
// that marks registers with an in-flight writer. A claim sets the busy bit,
// a write clears it, and a claim in the same cycle as a write to the same
// register wins because it represents a newer writer. npending is a
// registered popcount of the busy vector.
module reg_file_sb #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] raddr0,
  output logic [DATA_W-1:0] rdata0,
  output logic              rbusy0,
  input  logic [ADDR_W-1:0] raddr1,
  output logic [DATA_W-1:0] rdata1,
  output logic              rbusy1,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              wren,
  input  logic              claim_en,
  input  logic [ADDR_W-1:0] claim_addr,
  output logic [ADDR_W:0]   npending
);

  localparam int NREG = 1 << ADDR_W;

  logic [DATA_W-1:0] r_mem [NREG];
  logic [NREG-1:0]   r_busy;
  logic [ADDR_W:0]   r_npending;

  logic              w_wr_ok;
  logic              w_clm_ok;
  logic [NREG-1:0]   w_busy_nxt;
  logic [DATA_W-1:0] w_rdata0;
  logic [DATA_W-1:0] w_rdata1;
  logic              w_rbusy0;
  logic              w_rbusy1;

  // Number of set bits in a busy vector; NREG fits in ADDR_W+1 bits.
  function automatic logic [ADDR_W:0] popcount(input logic [NREG-1:0] v);
    logic [ADDR_W:0] cnt;
    cnt = '0;
    for (int i = 0; i < NREG; i++) begin
      cnt = cnt + {{ADDR_W{1'b0}}, v[i]};
    end
    return cnt;
  endfunction

  // Writes and claims aimed at the hard-wired zero register are dropped.
  always_comb begin
    w_wr_ok  = wren;
    w_clm_ok = claim_en;
    if ((ZERO_REG != 0) && (waddr == '0)) begin
      w_wr_ok = 1'b0;
    end else begin
      w_wr_ok = wren;
    end
    if ((ZERO_REG != 0) && (claim_addr == '0)) begin
      w_clm_ok = 1'b0;
    end else begin
      w_clm_ok = claim_en;
    end
  end

  // Next busy vector: the write retires first, then a claim re-arms, so a
  // same-address claim and write leave the register busy.
  always_comb begin
    w_busy_nxt = r_busy;
    if (w_wr_ok) begin
      w_busy_nxt[waddr] = 1'b0;
    end else begin
      w_busy_nxt[waddr] = r_busy[waddr];
    end
    if (w_clm_ok) begin
      w_busy_nxt[claim_addr] = 1'b1;
    end else begin
      w_busy_nxt[claim_addr] = w_busy_nxt[claim_addr];
    end
  end

  // Storage, busy vector and pending count; reset wins over any write or claim.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) begin
        r_mem[i] <= '0;
      end
      r_busy     <= '0;
      r_npending <= '0;
    end else begin
      if (w_wr_ok) begin
        r_mem[waddr] <= wdata;
      end
      r_busy     <= w_busy_nxt;
      r_npending <= popcount(w_busy_nxt);
    end
  end

  // Read port 0: zero register, then same-cycle forwarding, then storage.
  always_comb begin
    w_rdata0 = r_mem[raddr0];
    w_rbusy0 = r_busy[raddr0];
    if ((ZERO_REG != 0) && (raddr0 == '0)) begin
      w_rdata0 = '0;
      w_rbusy0 = 1'b0;
    end else if ((BYPASS != 0) && w_wr_ok && (waddr == raddr0)) begin
      w_rdata0 = wdata;
      w_rbusy0 = w_clm_ok && (claim_addr == raddr0);
    end else begin
      w_rdata0 = r_mem[raddr0];
      w_rbusy0 = r_busy[raddr0];
    end
  end

  // Read port 1: identical to port 0, fully independent.
  always_comb begin
    w_rdata1 = r_mem[raddr1];
    w_rbusy1 = r_busy[raddr1];
    if ((ZERO_REG != 0) && (raddr1 == '0)) begin
      w_rdata1 = '0;
      w_rbusy1 = 1'b0;
    end else if ((BYPASS != 0) && w_wr_ok && (waddr == raddr1)) begin
      w_rdata1 = wdata;
      w_rbusy1 = w_clm_ok && (claim_addr == raddr1);
    end else begin
      w_rdata1 = r_mem[raddr1];
      w_rbusy1 = r_busy[raddr1];
    end
  end

  assign rdata0   = w_rdata0;
  assign rbusy0   = w_rbusy0;
  assign rdata1   = w_rdata1;
  assign rbusy1   = w_rbusy1;
  assign npending = r_npending;

endmodule

// File: tb/tb_reg_file_sb.sv
// Self-checking bench for reg_file_sb: a default instance (bypass on), a
// no-bypass instance sharing its inputs, and a 64-bit/64-entry instance.
module tb_reg_file_sb;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [4:0]  raddr0, raddr1, waddr, claim_addr;
  logic [31:0] wdata;
  logic        wren, claim_en;

  logic [31:0] rdata0_a, rdata1_a, rdata0_b, rdata1_b;
  logic        rbusy0_a, rbusy1_a, rbusy0_b, rbusy1_b;
  logic [5:0]  npend_a, npend_b;

  logic [5:0]  x_raddr0, x_raddr1, x_waddr, x_claim_addr;
  logic [63:0] x_wdata, x_rdata0, x_rdata1;
  logic        x_wren, x_claim_en, x_rbusy0, x_rbusy1;
  logic [6:0]  x_npend;

  int checks = 0;
  int errors = 0;

  // Reference state: contents and outstanding-writer flags of the 32 registers.
  logic [31:0] m_mem [32];
  bit          m_busy [32];

  reg_file_sb u_dut_a (
    .clk(clk), .rst(rst),
    .raddr0(raddr0), .rdata0(rdata0_a), .rbusy0(rbusy0_a),
    .raddr1(raddr1), .rdata1(rdata1_a), .rbusy1(rbusy1_a),
    .waddr(waddr), .wdata(wdata), .wren(wren),
    .claim_en(claim_en), .claim_addr(claim_addr), .npending(npend_a)
  );

  reg_file_sb #(.BYPASS(0)) u_dut_b (
    .clk(clk), .rst(rst),
    .raddr0(raddr0), .rdata0(rdata0_b), .rbusy0(rbusy0_b),
    .raddr1(raddr1), .rdata1(rdata1_b), .rbusy1(rbusy1_b),
    .waddr(waddr), .wdata(wdata), .wren(wren),
    .claim_en(claim_en), .claim_addr(claim_addr), .npending(npend_b)
  );

  reg_file_sb #(.DATA_W(64), .ADDR_W(6)) u_dut_x (
    .clk(clk), .rst(rst),
    .raddr0(x_raddr0), .rdata0(x_rdata0), .rbusy0(x_rbusy0),
    .raddr1(x_raddr1), .rdata1(x_rdata1), .rbusy1(x_rbusy1),
    .waddr(x_waddr), .wdata(x_wdata), .wren(x_wren),
    .claim_en(x_claim_en), .claim_addr(x_claim_addr), .npending(x_npend)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] exp_rd(input logic [4:0] a, input bit byp);
    if (a == 5'd0) return 32'd0;
    if (byp && wren && waddr == a) return wdata;
    return m_mem[a];
  endfunction

  function automatic logic exp_busy(input logic [4:0] a, input bit byp);
    if (a == 5'd0) return 1'b0;
    if (byp && wren && waddr == a) return claim_en && (claim_addr == a);
    return m_busy[a];
  endfunction

  function automatic int count_busy();
    int n = 0;
    for (int i = 0; i < 32; i++) n += m_busy[i] ? 1 : 0;
    return n;
  endfunction

  task automatic drive(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                       input logic ce, input logic [4:0] ca,
                       input logic [4:0] ra0, input logic [4:0] ra1);
    wren = we; waddr = wa; wdata = wd;
    claim_en = ce; claim_addr = ca;
    raddr0 = ra0; raddr1 = ra1;
  endtask

  // One clock: check outputs against the model, take the edge, update the model.
  task automatic do_cycle(input bit chk_en);
    #1;
    if (chk_en) begin
      chk("rdata0_a", rdata0_a, exp_rd(raddr0, 1'b1));
      chk("rdata1_a", rdata1_a, exp_rd(raddr1, 1'b1));
      chk("rbusy0_a", rbusy0_a, exp_busy(raddr0, 1'b1));
      chk("rbusy1_a", rbusy1_a, exp_busy(raddr1, 1'b1));
      chk("rdata0_b", rdata0_b, exp_rd(raddr0, 1'b0));
      chk("rdata1_b", rdata1_b, exp_rd(raddr1, 1'b0));
      chk("rbusy0_b", rbusy0_b, exp_busy(raddr0, 1'b0));
      chk("npend_a", npend_a, 64'(count_busy()));
      chk("npend_b", npend_b, 64'(count_busy()));
    end
    @(posedge clk);
    if (rst) begin
      for (int i = 0; i < 32; i++) begin
        m_mem[i] = 32'd0;
        m_busy[i] = 1'b0;
      end
    end else begin
      if (wren && waddr != 5'd0) begin
        $display("REG[%d]=%d->%d", waddr, m_mem[waddr], wdata);
        m_mem[waddr] = wdata;
        m_busy[waddr] = 1'b0;
      end
      if (claim_en && claim_addr != 5'd0) m_busy[claim_addr] = 1'b1;
    end
    @(negedge clk);
  endtask

  initial begin
    for (int i = 0; i < 32; i++) begin
      m_mem[i] = 32'd0;
      m_busy[i] = 1'b0;
    end
    x_raddr0 = 6'd0; x_raddr1 = 6'd0; x_waddr = 6'd0; x_claim_addr = 6'd0;
    x_wdata = 64'd0; x_wren = 1'b0; x_claim_en = 1'b0;
    rst = 1'b1;
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd0, 5'd0);
    @(negedge clk);
    do_cycle(1'b0);
    rst = 1'b0;

    // Reset state
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd5, 5'd31);
    #1;
    chk("reset_npend", npend_a, 64'd0);
    chk("reset_rd31", rdata1_a, 64'd0);
    do_cycle(1'b1);

    // Write r5 then read it on both ports
    drive(1'b1, 5'd5, 32'h1234, 1'b0, 5'd0, 5'd1, 5'd2);
    do_cycle(1'b1);
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd5, 5'd5);
    #1;
    chk("r5_port0", rdata0_a, 64'h1234);
    chk("r5_port1", rdata1_a, 64'h1234);
    chk("r5_busy", rbusy0_a, 64'd0);
    chk("r5_npend", npend_a, 64'd0);
    do_cycle(1'b1);

    // Write and claim of r0 are discarded
    drive(1'b1, 5'd0, 32'hFFFF, 1'b1, 5'd0, 5'd0, 5'd0);
    do_cycle(1'b1);
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd0, 5'd0);
    #1;
    chk("r0_data", rdata0_a, 64'd0);
    chk("r0_busy", rbusy0_a, 64'd0);
    chk("r0_npend", npend_a, 64'd0);
    do_cycle(1'b1);

    // Same-cycle bypass versus registered read
    drive(1'b1, 5'd7, 32'hAB, 1'b0, 5'd0, 5'd7, 5'd7);
    #1;
    chk("byp_on", rdata0_a, 64'hAB);
    chk("byp_off_old", rdata0_b, 64'd0);
    do_cycle(1'b1);
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd7, 5'd7);
    #1;
    chk("byp_off_new", rdata0_b, 64'hAB);
    do_cycle(1'b1);

    // Claim bookkeeping
    drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd3, 5'd3, 5'd4);
    do_cycle(1'b1);
    chk("clm3_npend", npend_a, 64'd1);
    drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd4, 5'd3, 5'd4);
    do_cycle(1'b1);
    chk("clm4_npend", npend_a, 64'd2);
    drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd3, 5'd3, 5'd4);
    do_cycle(1'b1);
    chk("clm3_again", npend_a, 64'd2);
    drive(1'b1, 5'd3, 32'h33, 1'b0, 5'd0, 5'd3, 5'd4);
    do_cycle(1'b1);
    chk("wr3_npend", npend_a, 64'd1);
    chk("wr3_busy", rbusy0_b, 64'd0);
    drive(1'b1, 5'd4, 32'h44, 1'b1, 5'd4, 5'd3, 5'd4);
    #1;
    chk("wr4clm4_byp_busy", rbusy1_a, 64'd1);
    do_cycle(1'b1);
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd3, 5'd4);
    #1;
    chk("wr4clm4_npend", npend_a, 64'd1);
    chk("wr4clm4_busy", rbusy1_a, 64'd1);
    chk("wr4clm4_data", rdata1_a, 64'h44);
    do_cycle(1'b1);

    // Reset during outstanding claims, with a write that must be lost
    for (int a = 1; a <= 8; a++) begin
      drive(1'b0, 5'd0, 32'd0, 1'b1, 5'(a), 5'(a), 5'd2);
      do_cycle(1'b1);
    end
    chk("clm1to8_npend", npend_a, 64'd8);
    rst = 1'b1;
    drive(1'b1, 5'd2, 32'd9, 1'b1, 5'd9, 5'd2, 5'd7);
    do_cycle(1'b1);
    rst = 1'b0;
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd2, 5'd7);
    #1;
    chk("rst_r2", rdata0_a, 64'd0);
    chk("rst_r7", rdata1_a, 64'd0);
    chk("rst_npend", npend_a, 64'd0);
    chk("rst_busy", rbusy0_a, 64'd0);
    do_cycle(1'b1);

    // Randomized traffic, biased toward a few registers to force collisions
    for (int n = 0; n < 400; n++) begin
      bit narrow;
      narrow = ($urandom_range(0, 1) == 0);
      rst = ($urandom_range(0, 59) == 0);
      drive(1'($urandom_range(0, 1)),
            narrow ? 5'($urandom_range(0, 7)) : 5'($urandom),
            32'($urandom),
            1'($urandom_range(0, 1)),
            narrow ? 5'($urandom_range(0, 7)) : 5'($urandom),
            narrow ? 5'($urandom_range(0, 7)) : 5'($urandom),
            narrow ? 5'($urandom_range(0, 7)) : 5'($urandom));
      do_cycle(1'b1);
    end
    rst = 1'b0;
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd0, 5'd0);
    do_cycle(1'b1);

    // Wide instance: full-width value in the top register, every register claimed
    x_wren = 1'b1; x_waddr = 6'd63; x_wdata = 64'hFFFF_FFFF_FFFF_FFFF;
    do_cycle(1'b1);
    x_wren = 1'b0;
    for (int a = 1; a <= 63; a++) begin
      x_claim_en = 1'b1; x_claim_addr = 6'(a);
      do_cycle(1'b1);
    end
    x_claim_en = 1'b0; x_raddr0 = 6'd63; x_raddr1 = 6'd63;
    #1;
    chk("wide_rd0", x_rdata0, 64'hFFFF_FFFF_FFFF_FFFF);
    chk("wide_rd1", x_rdata1, 64'hFFFF_FFFF_FFFF_FFFF);
    chk("wide_npend", x_npend, 64'd63);
    chk("wide_busy", x_rbusy0, 64'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
